// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and the LSU,
//            one outstanding transaction at a time, with a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              lsu_req_valid,
    input  logic              lsu_req_write,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic [1:0]        lsu_req_size,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    output logic              lsu_req_ready,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [1:0]        mem_req_size,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              if_stall,
    output logic              ex_stall,
    output logic              timeout_err
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_req  = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;

    localparam logic c_own_if  = 1'b0;
    localparam logic c_own_lsu = 1'b1;

    localparam int c_starve_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [DATA_W-1:0] c_nop = DATA_W'(32'h0000_0013);

    logic [1:0]            r_state;
    logic                  r_owner;
    logic [c_starve_w-1:0] r_starve;
    logic                  r_mem_req_valid;
    logic                  r_mem_req_write;
    logic [ADDR_W-1:0]     r_mem_req_addr;
    logic [1:0]            r_mem_req_size;
    logic [DATA_W-1:0]     r_mem_req_wdata;
    logic                  r_if_rsp_valid;
    logic [DATA_W-1:0]     r_if_rsp_data;
    logic                  r_lsu_rsp_valid;
    logic [DATA_W-1:0]     r_lsu_rsp_data;
    logic                  r_timeout_err;

    logic w_in_idle;
    logic w_starved;
    logic w_grant_lsu;
    logic w_grant_if;
    logic w_rsp_hit;
    logic w_expire;
    logic w_abort;

    assign w_in_idle   = (r_state == c_idle);
    assign w_starved   = (r_starve == c_starve_w'(STARVE_LIMIT)) & if_req_valid;
    assign w_grant_lsu = ~rst & w_in_idle & lsu_req_valid & ~w_starved;
    assign w_grant_if  = ~rst & w_in_idle & if_req_valid & ~w_grant_lsu;
    assign w_rsp_hit   = (r_state == c_wait) & mem_rsp_valid;
    // A response arriving in the expiry cycle beats the watchdog
    assign w_abort     = w_expire & ~w_rsp_hit;

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_watchdog
            localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
            logic [c_tmo_w-1:0] r_tmo;

            // Every entry to REQ comes from IDLE, so holding zero in IDLE clears it
            always_ff @(posedge clk) begin
                if (rst || w_in_idle) begin
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + c_tmo_w'(1);
                end
            end

            assign w_expire = ~w_in_idle & (r_tmo == c_tmo_w'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_watchdog
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (~if_req_valid || w_grant_if) begin
            r_starve <= '0;
        end else if (w_grant_lsu && (r_starve != c_starve_w'(STARVE_LIMIT))) begin
            r_starve <= r_starve + c_starve_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_idle;
            r_owner         <= c_own_if;
            r_mem_req_valid <= 1'b0;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_size  <= 2'b00;
            r_mem_req_wdata <= '0;
            r_if_rsp_valid  <= 1'b0;
            r_if_rsp_data   <= '0;
            r_lsu_rsp_valid <= 1'b0;
            r_lsu_rsp_data  <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_if_rsp_valid  <= 1'b0;
            r_lsu_rsp_valid <= 1'b0;

            case (r_state)
                c_idle: begin
                    if (w_grant_lsu || w_grant_if) begin
                        r_owner         <= w_grant_lsu ? c_own_lsu : c_own_if;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_write <= w_grant_lsu & lsu_req_write;
                        r_mem_req_addr  <= w_grant_lsu ? lsu_req_addr : if_req_addr;
                        r_mem_req_size  <= w_grant_lsu ? lsu_req_size : 2'b00;
                        r_mem_req_wdata <= w_grant_lsu ? lsu_req_wdata : '0;
                        r_state         <= c_req;
                    end
                end
                c_req: begin
                    if (w_abort) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= c_idle;
                    end else if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= c_wait;
                    end
                end
                c_wait: begin
                    if (w_rsp_hit || w_abort) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= c_idle;
                end
            endcase

            if (w_rsp_hit || w_abort) begin
                if (r_owner == c_own_lsu) begin
                    r_lsu_rsp_valid <= 1'b1;
                    r_lsu_rsp_data  <= (w_rsp_hit && !r_mem_req_write) ? mem_rsp_data : '0;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= w_rsp_hit ? mem_rsp_data : c_nop;
                end
            end

            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign if_req_ready  = w_grant_if;
    assign lsu_req_ready = w_grant_lsu;
    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rsp_data   = r_if_rsp_data;
    assign lsu_rsp_valid = r_lsu_rsp_valid;
    assign lsu_rsp_data  = r_lsu_rsp_data;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_write = r_mem_req_write;
    assign mem_req_addr  = r_mem_req_addr;
    assign mem_req_size  = r_mem_req_size;
    assign mem_req_wdata = r_mem_req_wdata;
    assign timeout_err   = r_timeout_err;

    assign if_stall = ~rst & ((if_req_valid & ~w_grant_if & ~r_if_rsp_valid) |
                              (~w_in_idle & (r_owner == c_own_if)));
    assign ex_stall = ~rst & ((lsu_req_valid & ~w_grant_lsu & ~r_lsu_rsp_valid) |
                              (~w_in_idle & (r_owner == c_own_lsu)));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_write;
    logic [31:0] lsu_req_addr;
    logic [1:0]  lsu_req_size;
    logic [31:0] lsu_req_wdata;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        if_stall;
    logic        ex_stall;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .STARVE_LIMIT   (4),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_data   (if_rsp_data),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_write (lsu_req_write),
        .lsu_req_addr  (lsu_req_addr),
        .lsu_req_size  (lsu_req_size),
        .lsu_req_wdata (lsu_req_wdata),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_write (mem_req_write),
        .mem_req_addr  (mem_req_addr),
        .mem_req_size  (mem_req_size),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .if_stall      (if_stall),
        .ex_stall      (ex_stall),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_ready"},  if_req_ready,  0);
        check({tag, "_if_rsp_v"},  if_rsp_valid,  0);
        check({tag, "_if_rsp_d"},  if_rsp_data,   0);
        check({tag, "_lsu_ready"}, lsu_req_ready, 0);
        check({tag, "_lsu_rsp_v"}, lsu_rsp_valid, 0);
        check({tag, "_lsu_rsp_d"}, lsu_rsp_data,  0);
        check({tag, "_mem_valid"}, mem_req_valid, 0);
        check({tag, "_mem_write"}, mem_req_write, 0);
        check({tag, "_mem_addr"},  mem_req_addr,  0);
        check({tag, "_mem_size"},  mem_req_size,  0);
        check({tag, "_mem_wdata"}, mem_req_wdata, 0);
        check({tag, "_if_stall"},  if_stall,      0);
        check({tag, "_ex_stall"},  ex_stall,      0);
        check({tag, "_tmo_err"},   timeout_err,   0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        if_req_valid = 0; if_req_addr = 0;
        lsu_req_valid = 0; lsu_req_write = 0; lsu_req_addr = 0; lsu_req_size = 0; lsu_req_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        repeat (3) tick();
        rst = 1'b0;
        settle();
        check_all_zero("reset");

        // Single fetch at minimum latency
        if_req_valid = 1; if_req_addr = 32'h10;
        settle();
        check("t1_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0; mem_req_ready = 1;
        settle();
        check("t1_mem_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_req_addr, 32'h10);
        check("t1_mem_size", mem_req_size, 0);
        check("t1_stall_c1", if_stall, 1);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0050_0093;
        settle();
        check("t1_mem_valid_c2", mem_req_valid, 0);
        check("t1_stall_c2", if_stall, 1);
        check("t1_rsp_c2", if_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0;
        settle();
        check("t1_rsp_c3", if_rsp_valid, 1);
        check("t1_data_c3", if_rsp_data, 32'h0050_0093);
        check("t1_stall_c3", if_stall, 0);
        tick();
        check("t1_rsp_c4", if_rsp_valid, 0);

        // IF and LSU load in the same cycle: LSU first
        if_req_valid = 1; if_req_addr = 32'h40;
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h80; lsu_req_size = 2'b10;
        settle();
        check("t2_lsu_ready", lsu_req_ready, 1);
        check("t2_if_ready", if_req_ready, 0);
        check("t2_if_stall_c0", if_stall, 1);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        settle();
        check("t2_mem_addr_lsu", mem_req_addr, 32'h80);
        check("t2_mem_size_lsu", mem_req_size, 2'b10);
        check("t2_if_stall_c1", if_stall, 1);
        check("t2_ex_stall_c1", ex_stall, 1);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
        settle();
        check("t2_if_ready_wait", if_req_ready, 0);
        check("t2_if_stall_c2", if_stall, 1);
        tick();
        mem_rsp_valid = 0;
        settle();
        check("t2_lsu_rsp", lsu_rsp_valid, 1);
        check("t2_lsu_data", lsu_rsp_data, 32'h1111_2222);
        check("t2_ex_stall_c3", ex_stall, 0);
        check("t2_if_ready_c3", if_req_ready, 1);
        tick();
        if_req_valid = 0; mem_req_ready = 1;
        settle();
        check("t2_mem_addr_if", mem_req_addr, 32'h40);
        check("t2_if_stall_c4", if_stall, 1);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA_5555;
        settle();
        check("t2_if_stall_c5", if_stall, 1);
        tick();
        mem_rsp_valid = 0;
        settle();
        check("t2_if_rsp", if_rsp_valid, 1);
        check("t2_if_data", if_rsp_data, 32'hAAAA_5555);
        check("t2_if_stall_c6", if_stall, 0);
        tick();

        // Starvation: four LSU grants, then IF, then LSU again
        if_req_valid = 1; if_req_addr = 32'h100;
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h200; lsu_req_size = 2'b01;
        settle();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_lsu_ready_%0d", k), lsu_req_ready, (k != 4));
            check($sformatf("t3_if_ready_%0d", k), if_req_ready, (k == 4));
            if (k > 0) begin
                check($sformatf("t3_lsu_rsp_%0d", k - 1), lsu_rsp_valid, ((k - 1) != 4));
                check($sformatf("t3_if_rsp_%0d", k - 1), if_rsp_valid, ((k - 1) == 4));
            end
            tick();
            if (k == 5) begin
                if_req_valid = 0; lsu_req_valid = 0;
            end
            mem_req_ready = 1;
            settle();
            check($sformatf("t3_addr_%0d", k), mem_req_addr, (k == 4) ? 32'h100 : 32'h200);
            tick();
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'(k);
            tick();
            mem_rsp_valid = 0;
            settle();
        end
        check("t3_last_lsu_rsp", lsu_rsp_valid, 1);
        check("t3_last_lsu_data", lsu_rsp_data, 32'd5);
        check("t3_last_ex_stall", ex_stall, 0);
        tick();

        // Store with three cycles of back-pressure
        lsu_req_valid = 1; lsu_req_write = 1; lsu_req_addr = 32'h20;
        lsu_req_size = 2'b10; lsu_req_wdata = 32'hCAFE_BABE;
        settle();
        check("t4_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0; lsu_req_write = 0; lsu_req_addr = 32'hFFFF_FFFF;
        lsu_req_size = 2'b00; lsu_req_wdata = 32'h0;
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t4_valid_%0d", i), mem_req_valid, 1);
            check($sformatf("t4_write_%0d", i), mem_req_write, 1);
            check($sformatf("t4_addr_%0d", i), mem_req_addr, 32'h20);
            check($sformatf("t4_size_%0d", i), mem_req_size, 2'b10);
            check($sformatf("t4_wdata_%0d", i), mem_req_wdata, 32'hCAFE_BABE);
            tick();
        end
        mem_req_ready = 1;
        settle();
        check("t4_valid_accept", mem_req_valid, 1);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
        settle();
        check("t4_valid_wait", mem_req_valid, 0);
        check("t4_rsp_early", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0;
        settle();
        check("t4_lsu_rsp", lsu_rsp_valid, 1);
        check("t4_lsu_data", lsu_rsp_data, 0);
        check("t4_ex_stall", ex_stall, 0);
        tick();

        // Watchdog on an LSU load that is accepted but never answered
        lsu_req_valid = 1; lsu_req_write = 0; lsu_req_addr = 32'h30; lsu_req_size = 2'b10;
        settle();
        check("t5_lsu_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        repeat (6) tick();
        check("t5_err_c8", timeout_err, 0);
        check("t5_rsp_c8", lsu_rsp_valid, 0);
        check("t5_stall_c8", ex_stall, 1);
        tick();
        check("t5_rsp_c9", lsu_rsp_valid, 1);
        check("t5_data_c9", lsu_rsp_data, 0);
        check("t5_err_c9", timeout_err, 1);
        check("t5_stall_c9", ex_stall, 0);
        tick();
        mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
        tick();
        mem_rsp_valid = 0;
        check("t5_stray_lsu", lsu_rsp_valid, 0);
        check("t5_stray_if", if_rsp_valid, 0);
        check("t5_err_sticky", timeout_err, 1);

        // Watchdog on a fetch the memory never accepts: NOP returned
        if_req_valid = 1; if_req_addr = 32'h50;
        settle();
        check("t5b_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        repeat (7) tick();
        check("t5b_valid_c8", mem_req_valid, 1);
        check("t5b_rsp_c8", if_rsp_valid, 0);
        tick();
        check("t5b_valid_c9", mem_req_valid, 0);
        check("t5b_rsp_c9", if_rsp_valid, 1);
        check("t5b_data_c9", if_rsp_data, 32'h0000_0013);
        tick();

        // Reset in WAIT abandons the transaction
        if_req_valid = 1; if_req_addr = 32'h60;
        tick();
        if_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; rst = 1;
        tick();
        rst = 0;
        settle();
        check_all_zero("t6");
        mem_rsp_valid = 1; mem_rsp_data = 32'h5555_AAAA;
        tick();
        mem_rsp_valid = 0;
        settle();
        check("t6_late_if_rsp", if_rsp_valid, 0);
        check("t6_late_lsu_rsp", lsu_rsp_valid, 0);
        if_req_valid = 1; if_req_addr = 32'h70;
        settle();
        check("t6_regrant", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        settle();
        check("t6_regrant_addr", mem_req_addr, 32'h70);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
